// File: rtl/sign_extend_arbiter.sv
// Two-requester sign-extension unit: requesters A (branch offset) and B
// (ALU immediate) share one 16->32 sign extender. A round-robin pointer
// settles contention, and a single-entry output register with valid/ready
// holds the extended result for the consumer.
//
// Output handshake: out_valid/out_data/out_src stay stable while
// out_valid=1 and out_ready=0. A transfer happens on a rising edge where
// out_valid=1 and out_ready=1. The register can be refilled in the same
// cycle it is drained, which gives one result per cycle.

// Pure combinational 16->32 sign extension (bit 15 copied into 31:16).
module signExtendBlock (
   input  logic [15:0] inp,
   output logic [31:0] out
);
   assign out = {{16{inp[15]}}, inp};
endmodule

module sign_extend_arbiter #(
   parameter logic PRIO_RESET = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_a,
   input  logic [15:0] imm_a,
   output logic        ack_a,
   input  logic        req_b,
   input  logic [15:0] imm_b,
   output logic        ack_b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic        out_src,
   output logic [7:0]  stall_cnt
);

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   state_t      state;
   state_t      state_next;
   logic        prio;       // requester favoured on contention: 0 = A, 1 = B
   logic        load;       // output register is free or being drained
   logic        grant_a;
   logic        grant_b;
   logic [15:0] imm_sel;
   logic [31:0] imm_ext;

   // Single shared extender, fed by whichever requester wins.
   assign imm_sel = grant_b ? imm_b : imm_a;

   signExtendBlock u_sign_extend (
      .inp (imm_sel),
      .out (imm_ext)
   );

   // Next-state and grant decode; acks are only offered in load cycles.
   always_comb begin
      state_next = state;
      load       = 1'b0;
      grant_a    = 1'b0;
      grant_b    = 1'b0;
      case (state)
         IDLE: load = 1'b1;
         HOLD: load = out_ready;
         default: load = 1'b0;
      endcase
      if (load) begin
         grant_a = req_a && (!req_b || (prio == 1'b0));
         grant_b = req_b && (!req_a || (prio == 1'b1));
         state_next = (grant_a || grant_b) ? HOLD : IDLE;
      end
   end

   // Acks are masked by reset so a held-low rst never lets one through.
   assign ack_a     = grant_a & rst;
   assign ack_b     = grant_b & rst;
   assign out_valid = (state == HOLD);

   // FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Result capture and round-robin pointer update on every grant.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_data <= 32'h0;
         out_src  <= 1'b0;
         prio     <= PRIO_RESET;
      end else if (grant_a || grant_b) begin
         out_data <= imm_ext;
         out_src  <= grant_b;
         prio     <= ~grant_b;
      end
   end

   // Saturating count of cycles where a result waits on the consumer.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt <= 8'h0;
      end else if ((state == HOLD) && !out_ready && (stall_cnt != 8'hFF)) begin
         stall_cnt <= stall_cnt + 8'h1;
      end
   end

endmodule

// File: tb/tb_sign_extend_arbiter.sv
// Bench for sign_extend_arbiter: directed vector table, hand-written
// contention / backpressure / reset sequences, then random traffic
// compared against a behavioural model with an expected-result queue.
module tb_sign_extend_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_a;
   logic [15:0] imm_a;
   logic        ack_a;
   logic        req_b;
   logic [15:0] imm_b;
   logic        ack_b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        out_src;
   logic [7:0]  stall_cnt;

   int checks = 0;
   int errors = 0;

   sign_extend_arbiter #(.PRIO_RESET(1'b0)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_a     (req_a),
      .imm_a     (imm_a),
      .ack_a     (ack_a),
      .req_b     (req_b),
      .imm_b     (imm_b),
      .ack_b     (ack_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_src   (out_src),
      .stall_cnt (stall_cnt)
   );

   // Clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference model: a one-deep result store as a queue of {src,data},
   // the last captured result, a round-robin pointer and a stall counter.
   logic [32:0] exp_q[$];
   logic [32:0] m_last;
   logic        m_prio;
   int          m_stall;
   logic        s_ack_a;
   logic        s_ack_b;

   function automatic logic [31:0] sext(input logic [15:0] v);
      if (v >= 16'd32768) return 32'(v) + 32'hFFFF_0000;
      return 32'(v);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_last  = 33'h0;
      m_prio  = 1'b0;
      m_stall = 0;
   endtask

   // Reset driver: leaves inputs idle, releases rst 1 time unit after an edge.
   task automatic apply_reset();
      req_a = 1'b0; req_b = 1'b0; imm_a = '0; imm_b = '0; out_ready = 1'b0;
      rst = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", 32'(out_valid), 32'h0);
      check("rst_data", out_data, 32'h0);
      check("rst_src", 32'(out_src), 32'h0);
      check("rst_stall", 32'(stall_cnt), 32'h0);
      rst = 1'b1;
   endtask

   // Driver + scoreboard for one cycle; called at edge+1, returns at edge+1.
   task automatic run_cycle(input logic ra, input logic [15:0] ia,
                            input logic rb, input logic [15:0] ib, input logic rdy);
      logic mv, ld, wa, wb;
      req_a = ra; imm_a = ia; req_b = rb; imm_b = ib; out_ready = rdy;
      #1;
      mv = (exp_q.size() != 0);
      ld = !mv || rdy;
      wa = ld && ra && (!rb || (m_prio == 1'b0));
      wb = ld && rb && (!ra || (m_prio == 1'b1));
      s_ack_a = ack_a;
      s_ack_b = ack_b;
      check("ack_a", 32'(ack_a), 32'(wa));
      check("ack_b", 32'(ack_b), 32'(wb));
      check("out_valid", 32'(out_valid), 32'(mv));
      check("out_data", out_data, m_last[31:0]);
      check("out_src", 32'(out_src), 32'(m_last[32]));
      check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
      @(posedge clk);
      if (mv && !rdy && m_stall < 255) m_stall++;
      if (mv && rdy) void'(exp_q.pop_front());
      if (wa) begin
         m_last = {1'b0, sext(ia)};
         exp_q.push_back(m_last);
         m_prio = 1'b1;
      end else if (wb) begin
         m_last = {1'b1, sext(ib)};
         exp_q.push_back(m_last);
         m_prio = 1'b0;
      end
      #1;
   endtask

   typedef struct {
      logic        ra;
      logic [15:0] ia;
      logic        rb;
      logic [15:0] ib;
      logic        rdy;
      logic        e_ack_a;
      logic        e_ack_b;
      logic        e_valid;
      logic [31:0] e_data;
      logic        e_src;
   } vec_t;

   vec_t vecs[9];

   initial begin
      logic [31:0] held;
      logic        ra, rb, prev_ra, prev_rb;
      logic [15:0] ia, ib;

      // Directed table: expectations are for this cycle's acks and the
      // registered outputs after the edge.
      vecs[0] = '{1'b1, 16'h8001, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFF8001, 1'b0};
      vecs[1] = '{1'b0, 16'h0000, 1'b1, 16'h7FFF, 1'b1, 1'b0, 1'b1, 1'b1, 32'h00007FFF, 1'b1};
      vecs[2] = '{1'b1, 16'h1234, 1'b1, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b1, 32'h00001234, 1'b0};
      vecs[3] = '{1'b1, 16'h1234, 1'b1, 16'h8000, 1'b1, 1'b0, 1'b1, 1'b1, 32'hFFFF8000, 1'b1};
      vecs[4] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF8000, 1'b1};
      vecs[5] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFF8000, 1'b1};
      vecs[6] = '{1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 32'h00000000, 1'b1};
      vecs[7] = '{1'b1, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 32'h00000000, 1'b1};
      vecs[8] = '{1'b1, 16'hFFFF, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0};

      apply_reset();
      foreach (vecs[i]) begin
         run_cycle(vecs[i].ra, vecs[i].ia, vecs[i].rb, vecs[i].ib, vecs[i].rdy);
         check($sformatf("vec%0d_ack_a", i), 32'(s_ack_a), 32'(vecs[i].e_ack_a));
         check($sformatf("vec%0d_ack_b", i), 32'(s_ack_b), 32'(vecs[i].e_ack_b));
         check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].e_valid));
         check($sformatf("vec%0d_data", i), out_data, vecs[i].e_data);
         check($sformatf("vec%0d_src", i), 32'(out_src), 32'(vecs[i].e_src));
      end

      // Contention from a fresh reset: A,B,A,B with out_src one cycle later.
      apply_reset();
      for (int i = 0; i < 4; i++) begin
         run_cycle(1'b1, 16'h00A0, 1'b1, 16'h00B0, 1'b1);
         check("cont_ack_a", 32'(s_ack_a), 32'((i % 2) == 0));
         check("cont_ack_b", 32'(s_ack_b), 32'((i % 2) == 1));
         check("cont_src", 32'(out_src), 32'((i % 2) == 1));
      end

      // Backpressure: result pending, consumer stalls for 300 cycles.
      held = out_data;
      for (int i = 0; i < 300; i++) begin
         run_cycle(1'b1, 16'h4321, 1'b0, 16'h0000, 1'b0);
         check("bp_no_ack", 32'(s_ack_a), 32'h0);
         check("bp_data_stable", out_data, held);
      end
      check("bp_stall_sat", 32'(stall_cnt), 32'd255);
      run_cycle(1'b1, 16'h4321, 1'b0, 16'h0000, 1'b1);
      check("bp_ack_on_ready", 32'(s_ack_a), 32'h1);
      check("bp_new_data", out_data, 32'h00004321);

      // Reset while a result is held: clears without a clock edge.
      check("pre_rst_valid", 32'(out_valid), 32'h1);
      req_a = 1'b1;
      out_ready = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      check("arst_valid", 32'(out_valid), 32'h0);
      check("arst_data", out_data, 32'h0);
      check("arst_stall", 32'(stall_cnt), 32'h0);
      check("arst_ack_a", 32'(ack_a), 32'h0);
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
      run_cycle(1'b0, 16'h0000, 1'b1, 16'h9ABC, 1'b1);
      check("post_rst_ack_b", 32'(s_ack_b), 32'h1);
      check("post_rst_data", out_data, 32'hFFFF9ABC);

      // Random traffic against the model; immediates held while requested.
      apply_reset();
      prev_ra = 1'b0; prev_rb = 1'b0; ia = '0; ib = '0;
      s_ack_a = 1'b0; s_ack_b = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (!prev_ra || s_ack_a) ia = 16'($urandom);
         if (!prev_rb || s_ack_b) ib = 16'($urandom);
         ra = ($urandom_range(0, 3) != 0);
         rb = ($urandom_range(0, 3) != 0);
         run_cycle(ra, ia, rb, ib, ($urandom_range(0, 3) != 0));
         prev_ra = ra;
         prev_rb = rb;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sign_extend_arbiter.md
SIGN_EXTEND_ARBITER -- requirements
Module: sign_extend_arbiter

Interface
REQ-001 The block SHALL have one parameter: PRIO_RESET, default 0, meaning the requester favoured first after reset (0 = A, 1 = B).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port req_a, input, 1 bit: requester A (branch-offset path) has a 16-bit immediate pending.
REQ-005 The block SHALL have port imm_a, input, 16 bits: requester A immediate, stable while req_a is high.
REQ-006 The block SHALL have port ack_a, output, 1 bit: one-cycle pulse, imm_a captured this cycle.
REQ-007 The block SHALL have ports req_b (input, 1 bit), imm_b (input, 16 bits) and ack_b (output, 1 bit): requester B (ALU-immediate path), same semantics as A.
REQ-008 The block SHALL have port out_valid, output, 1 bit: out_data/out_src hold a result.
REQ-009 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result this cycle when out_valid is high.
REQ-010 The block SHALL have port out_data, output, 32 bits: the sign-extended immediate.
REQ-011 The block SHALL have port out_src, output, 1 bit: owner of out_data (0 = A, 1 = B).
REQ-012 The block SHALL have port stall_cnt, output, 8 bits: saturating count of cycles with out_valid=1 and out_ready=0.

Function
REQ-013 The block SHALL contain exactly one signExtendBlock instance (16-bit inp to 32-bit out, bit 15 replicated into bits 31:16), shared by both requesters.
REQ-014 The block SHALL implement FSM states IDLE (out_valid=0) and HOLD (out_valid=1).
REQ-015 The load condition SHALL be defined as state IDLE, or state HOLD with out_ready=1.
REQ-016 Under load with exactly one request high, that requester SHALL be granted.
REQ-017 Under load with both requests high, the requester named by the priority pointer SHALL be granted, and the pointer SHALL then point to the other requester.
REQ-018 A grant with a single request SHALL also set the pointer to the non-granted requester.
REQ-019 ack_x SHALL be combinational and high only in the grant cycle: at most one ack per cycle, and neither ack outside a load cycle.
REQ-020 On the edge ending a grant cycle, out_data SHALL capture signExtendBlock(imm of the granted requester), out_src SHALL capture the granted id, and the state SHALL become HOLD; latency from ack to out_valid is 1 cycle.
REQ-021 In a load cycle with no request, the state SHALL become IDLE and out_data/out_src SHALL keep their values.
REQ-022 In HOLD with out_ready=0, out_data, out_src and the state SHALL be held, and no ack SHALL be issued.
REQ-023 In HOLD with out_ready=1 and a request present, the result SHALL be consumed and a new grant issued in the same cycle, giving back-to-back throughput of 1 per cycle.
REQ-024 stall_cnt SHALL increment in each HOLD cycle with out_ready=0, saturate at 255 and never wrap.
REQ-025 A request dropped before its ack SHALL be ignored, with no state change.

Reset
REQ-026 While rst=0, asynchronously: state=IDLE, out_valid=0, out_data=32'h0, out_src=0, stall_cnt=0, priority pointer=PRIO_RESET, and ack_a=ack_b=0 regardless of requests.
REQ-027 Reset asserted in HOLD SHALL discard the pending result, and no ack SHALL issue in the reset cycle.
REQ-028 The first load cycle after rst returns to 1 SHALL arbitrate normally.

Verification
REQ-029 The bench SHALL cover single request: req_a=1, imm_a=16'h8001, out_ready=1 -> ack_a pulse, next cycle out_valid=1, out_data=32'hFFFF8001, out_src=0.
REQ-030 The bench SHALL cover positive extension: req_b=1, imm_b=16'h7FFF -> out_data=32'h00007FFF, out_src=1.
REQ-031 The bench SHALL cover contention: req_a=req_b=1 held, out_ready=1, PRIO_RESET=0 -> acks alternate A,B,A,B on consecutive cycles, and out_src follows one cycle later.
REQ-032 The bench SHALL cover backpressure: result pending, out_ready=0 for 300 cycles with req_a=1 -> no ack, out_data stable, stall_cnt stops at 255, and ack_a issues in the cycle out_ready rises.
REQ-033 The bench SHALL cover reset mid-HOLD: rst=0 while out_valid=1 -> out_valid=0, out_data=0 and stall_cnt=0 immediately without a clock edge, and after release with req_b=1 only, ack_b is issued.
